signed_div_ctrl: RTL and testbench

Front-end controller for the datapath divider. It accepts a signed or unsigned 32-bit divide request, screens divide-by-zero and signed-overflow operands, and converts the operands to magnitudes. It then launches the unsigned restoring-division core, waits for completion under a timeout, and applies sign correction. It presents quotient (LO) and remainder (HI) to the HI/LO register writeback through a valid/ready handshake.

---
 rtl/div_pkg.sv | 23 ++
 rtl/twos_magnitude.sv | 17 +
 rtl/signed_div_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_signed_div_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divider front-end controller.
// No logic; constants only.
// No handshakes; consumed at elaboration.
package div_pkg;

    localparam int WIDTH          = 32;
    localparam int TIMEOUT_CYCLES = 40;

    // Quotient reported for a zero divisor.
    localparam logic [WIDTH-1:0] DIV_ZERO_LO = '1;
    // Most negative two's-complement value; its magnitude is itself.
    localparam logic [WIDTH-1:0] SIGNED_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ISSUE,
        S_WAIT,
        S_FIX,
        S_RESP
    } state_e;

endpackage

// File: rtl/twos_magnitude.sv
// Conditional two's-complement negate (magnitude and sign fix-up).
// Purely combinational, zero latency.
// No flow control.
module twos_magnitude #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             negate_i,
    output logic [WIDTH-1:0] result_o
);

    // Negate as ~x+1 in modular arithmetic; the most negative value maps to itself.
    always_comb begin
        result_o = negate_i ? (~value_i + WIDTH'(1)) : value_i;
    end

endmodule

// File: rtl/signed_div_ctrl.sv
// Divider front-end: screens zero/overflow, drives the unsigned core, sign-fixes results.
// Request to core_start 2 cycles; done to rsp_valid 2 cycles; short paths 2 cycles.
// Holds results in RESP until rsp_ready; req_ready only high in IDLE.
module signed_div_ctrl #(
    parameter int WIDTH          = div_pkg::WIDTH,
    parameter int TIMEOUT_CYCLES = div_pkg::TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_dividend,
    input  logic [WIDTH-1:0] req_divisor,
    input  logic             req_signed,
    output logic             core_start,
    output logic [WIDTH-1:0] core_dividend,
    output logic [WIDTH-1:0] core_divisor,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_quotient,
    input  logic [WIDTH-1:0] core_remainder,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero,
    output logic             timeout
);

    import div_pkg::*;

    localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             core_start_q, core_start_d;
    logic [WIDTH-1:0] core_dividend_q, core_dividend_d;
    logic [WIDTH-1:0] core_divisor_q, core_divisor_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_zero_q, div_zero_d;
    logic             timeout_q, timeout_d;

    logic [WIDTH-1:0] mag_a, mag_b, fix_quo, fix_rem;
    logic             overflow;

    twos_magnitude #(.WIDTH(WIDTH)) u_mag_a (
        .value_i  (a_q),
        .negate_i (signed_q & a_q[WIDTH-1]),
        .result_o (mag_a)
    );

    twos_magnitude #(.WIDTH(WIDTH)) u_mag_b (
        .value_i  (b_q),
        .negate_i (signed_q & b_q[WIDTH-1]),
        .result_o (mag_b)
    );

    twos_magnitude #(.WIDTH(WIDTH)) u_fix_quo (
        .value_i  (quo_q),
        .negate_i (neg_quo_q),
        .result_o (fix_quo)
    );

    twos_magnitude #(.WIDTH(WIDTH)) u_fix_rem (
        .value_i  (rem_q),
        .negate_i (neg_rem_q),
        .result_o (fix_rem)
    );

    // MIN / -1 overflows the signed quotient; answered without the core.
    assign overflow = signed_q && (a_q == SIGNED_MIN) && (b_q == '1);

    assign req_ready     = (state_q == S_IDLE);
    assign core_start    = core_start_q;
    assign core_dividend = core_dividend_q;
    assign core_divisor  = core_divisor_q;
    assign rsp_valid     = rsp_valid_q;
    assign hi            = hi_q;
    assign lo            = lo_q;
    assign div_zero      = div_zero_q;
    assign timeout       = timeout_q;

    // Next-state and registered-output decode for the request/response sequence.
    always_comb begin
        state_d         = state_q;
        a_d             = a_q;
        b_d             = b_q;
        signed_d        = signed_q;
        neg_quo_d       = neg_quo_q;
        neg_rem_d       = neg_rem_q;
        quo_d           = quo_q;
        rem_d           = rem_q;
        cnt_d           = cnt_q;
        core_start_d    = 1'b0;
        core_dividend_d = core_dividend_q;
        core_divisor_d  = core_divisor_q;
        rsp_valid_d     = rsp_valid_q;
        hi_d            = hi_q;
        lo_d            = lo_q;
        div_zero_d      = div_zero_q;
        timeout_d       = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    a_d      = req_dividend;
                    b_d      = req_divisor;
                    signed_d = req_signed;
                    state_d  = S_PREP;
                end
            end
            S_PREP: begin
                neg_quo_d = signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_rem_d = signed_q & a_q[WIDTH-1];
                if (b_q == '0) begin
                    lo_d        = DIV_ZERO_LO;
                    hi_d        = a_q;
                    div_zero_d  = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (overflow) begin
                    lo_d        = SIGNED_MIN;
                    hi_d        = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    core_dividend_d = mag_a;
                    core_divisor_d  = mag_b;
                    core_start_d    = 1'b1;
                    state_d         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done on the final budgeted cycle still wins over the timeout.
                if (core_done) begin
                    quo_d   = core_quotient;
                    rem_d   = core_remainder;
                    state_d = S_FIX;
                end else if (cnt_q == CNT_LAST) begin
                    hi_d        = '0;
                    lo_d        = '0;
                    timeout_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIX: begin
                lo_d        = fix_quo;
                hi_d        = fix_rem;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    div_zero_d  = 1'b0;
                    timeout_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            a_q             <= '0;
            b_q             <= '0;
            signed_q        <= 1'b0;
            neg_quo_q       <= 1'b0;
            neg_rem_q       <= 1'b0;
            quo_q           <= '0;
            rem_q           <= '0;
            cnt_q           <= '0;
            core_start_q    <= 1'b0;
            core_dividend_q <= '0;
            core_divisor_q  <= '0;
            rsp_valid_q     <= 1'b0;
            hi_q            <= '0;
            lo_q            <= '0;
            div_zero_q      <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            a_q             <= a_d;
            b_q             <= b_d;
            signed_q        <= signed_d;
            neg_quo_q       <= neg_quo_d;
            neg_rem_q       <= neg_rem_d;
            quo_q           <= quo_d;
            rem_q           <= rem_d;
            cnt_q           <= cnt_d;
            core_start_q    <= core_start_d;
            core_dividend_q <= core_dividend_d;
            core_divisor_q  <= core_divisor_d;
            rsp_valid_q     <= rsp_valid_d;
            hi_q            <= hi_d;
            lo_q            <= lo_d;
            div_zero_q      <= div_zero_d;
            timeout_q       <= timeout_d;
        end
    end

endmodule

// File: tb/tb_signed_div_ctrl.sv
// Randomized scoreboard bench for signed_div_ctrl with a behavioural core stub.
// Expected results come from plain signed/unsigned arithmetic.
// Monitor drives rsp_ready (random or held low) and checks timing and stability.
module tb_signed_div_ctrl;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_dividend;
    logic [31:0] req_divisor;
    logic        req_signed;
    logic        core_start;
    logic [31:0] core_dividend;
    logic [31:0] core_divisor;
    logic        core_done;
    logic [31:0] model_q;
    logic [31:0] model_r;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;
    logic        timeout;

    logic model_done = 1'b0;
    logic stray_done = 1'b0;
    assign core_done = model_done | stray_done;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    signed_div_ctrl #(.WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dividend   (req_dividend),
        .req_divisor    (req_divisor),
        .req_signed     (req_signed),
        .core_start     (core_start),
        .core_dividend  (core_dividend),
        .core_divisor   (core_divisor),
        .core_done      (core_done),
        .core_quotient  (model_q),
        .core_remainder (model_r),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .hi             (hi),
        .lo             (lo),
        .div_zero       (div_zero),
        .timeout        (timeout)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        logic        to;
        int          at;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } core_exp_t;

    exp_t      sb[$];
    core_exp_t cq[$];

    int checks = 0;
    int errors = 0;

    int core_lat  = 10;
    bit core_hang = 1'b0;
    bit hold_low  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: results from ordinary signed/unsigned division, timing from the handshake contract.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                      input int lat, input bit hang, input int x,
                                      output exp_t e, output bit core_used, output core_exp_t ce);
        longint sa, sbv;
        e.lo = '0; e.hi = '0; e.dz = 1'b0; e.to = 1'b0; e.at = x + 2;
        ce.a = '0; ce.b = '0;
        core_used = 1'b0;
        if (b == 32'd0) begin
            e.lo = 32'hFFFF_FFFF;
            e.hi = a;
            e.dz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000;
            e.hi = 32'd0;
        end else begin
            core_used = 1'b1;
            if (s) begin
                sa   = longint'($signed(a));
                sbv  = longint'($signed(b));
                ce.a = 32'((sa  < 0) ? -sa  : sa);
                ce.b = 32'((sbv < 0) ? -sbv : sbv);
                e.lo = 32'(sa / sbv);
                e.hi = 32'(sa % sbv);
            end else begin
                ce.a = a;
                ce.b = b;
                e.lo = a / b;
                e.hi = a % b;
            end
            if (hang) begin
                e.lo = '0;
                e.hi = '0;
                e.to = 1'b1;
                e.at = x + 2 + TO + 1;
            end else begin
                e.at = x + 4 + lat;
            end
        end
    endfunction

    // Core stub: checks the operands it is launched with, answers after core_lat cycles.
    initial begin
        int        pend;
        core_exp_t ce;
        pend    = 0;
        model_q = '0;
        model_r = '0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (!reset) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) model_done = 1'b1;
                end
                if (core_start) begin
                    if (cq.size() == 0) begin
                        chk("unexpected_core_start", 64'd1, 64'd0);
                    end else begin
                        ce = cq.pop_front();
                        chk("core_dividend", core_dividend, ce.a);
                        chk("core_divisor", core_divisor, ce.b);
                    end
                    model_q = (core_divisor != 0) ? core_dividend / core_divisor : '0;
                    model_r = (core_divisor != 0) ? core_dividend % core_divisor : '0;
                    pend    = core_hang ? 0 : core_lat;
                end
            end
        end
    end

    // Monitor: response arrival time, stability while stalled, and payload at transfer.
    initial begin
        bit          prev_vld;
        logic [31:0] ph, pl;
        logic        pdz, pto;
        exp_t        e;
        prev_vld  = 1'b0;
        rsp_ready = 1'b0;
        ph = '0; pl = '0; pdz = 1'b0; pto = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_vld  = 1'b0;
                rsp_ready = 1'b0;
                continue;
            end
            if (rsp_valid) begin
                chk("req_ready_in_resp", req_ready, 1'b0);
                if (!prev_vld) begin
                    if (sb.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
                    else chk("rsp_arrival_cycle", 64'(cyc), 64'(sb[0].at));
                end else begin
                    chk("stall_hi_stable", hi, ph);
                    chk("stall_lo_stable", lo, pl);
                    chk("stall_flags_stable", {div_zero, timeout}, {pdz, pto});
                end
                ph = hi; pl = lo; pdz = div_zero; pto = timeout;
            end
            rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("lo", lo, e.lo);
                    chk("hi", hi, e.hi);
                    chk("div_zero", div_zero, e.dz);
                    chk("timeout", timeout, e.to);
                end
                prev_vld = 1'b0;
            end else begin
                prev_vld = rsp_valid;
            end
        end
    end

    // Issue one request (called at a negedge); push expectations for core and response.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int lat, input bit hang, input bit expect_rsp);
        exp_t      e;
        core_exp_t ce;
        bit        used;
        int        w;
        w = 0;
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            chk("req_ready_wait_expired", 64'd0, 64'd1);
            return;
        end
        core_lat     = lat;
        core_hang    = hang;
        req_valid    = 1'b1;
        req_dividend = a;
        req_divisor  = b;
        req_signed   = s;
        ref_model(a, b, s, lat, hang, cyc, e, used, ce);
        if (used) cq.push_back(ce);
        if (expect_rsp) sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((sb.size() != 0 || !req_ready) && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0 || !req_ready) chk("drain_wait_expired", 64'd0, 64'd1);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(1, 300));
            4:       v = 32'd0 - 32'($urandom_range(1, 300));
            default: v = $urandom();
        endcase
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1'b1);
        chk({tag, "_core_start"}, core_start, 1'b0);
        chk({tag, "_core_operands"}, {core_dividend, core_divisor}, 64'd0);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_hi_lo"}, {hi, lo}, 64'd0);
        chk({tag, "_flags"}, {div_zero, timeout}, 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got running expected finished");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_dividend = '0;
        req_divisor  = '0;
        req_signed   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        // Directed cases.
        send(32'd100, 32'd7, 1'b0, 33, 1'b0, 1'b1);
        wait_idle();
        send(32'hFFFF_FF9C, 32'd7, 1'b1, 5, 1'b0, 1'b1);
        wait_idle();
        send(32'd100, 32'd0, 1'b1, 5, 1'b0, 1'b1);
        wait_idle();
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5, 1'b0, 1'b1);
        wait_idle();
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1, 1'b0, 1'b1);
        wait_idle();
        send(32'hFFFF_FFF9, 32'd3, 1'b1, 39, 1'b0, 1'b1);
        wait_idle();

        // Core never completes, then a stray done while idle must not produce anything.
        send(32'd55, 32'd5, 1'b0, 0, 1'b1, 1'b1);
        wait_idle();
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stray_done_no_rsp", rsp_valid, 1'b0);
        end

        // Writeback stalled for several cycles.
        hold_low = 1'b1;
        send(32'hFFFF_FC00, 32'hFFFF_FFF0, 1'b1, 4, 1'b0, 1'b1);
        begin
            int w;
            w = 0;
            while (!rsp_valid && w < 100) begin
                @(negedge clk);
                w++;
            end
            chk("stall_rsp_seen", rsp_valid, 1'b1);
        end
        repeat (5) @(negedge clk);
        hold_low = 1'b0;
        wait_idle();

        // Reset during WAIT aborts; a late done is ignored; next request is clean.
        send(32'd1000, 32'd9, 1'b0, 0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        reset = 1'b1;
        chk("midreset_core_queue_empty", 64'(cq.size()), 64'd0);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post_reset_no_rsp", rsp_valid, 1'b0);
        end
        send(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 12, 1'b0, 1'b1);
        wait_idle();

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            send(pick(), pick(), 1'($urandom_range(0, 1)), $urandom_range(1, 39),
                 ($urandom_range(0, 9) == 0), 1'b1);
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("final_scoreboard_empty", 64'(sb.size()), 64'd0);
        chk("final_core_queue_empty", 64'(cq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
